bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential binary-to-packed-BCD converter (shift-and-add-3, one bit/cycle).
//   Sits directly upstream of the 8-digit seven-segment scanner: its bcd output
//   drives the scanner's 32-bit data input, so binary counts show as decimal.
//   A start/busy/done handshake lets the producer request a conversion.
//   bcd holds the last result during conversion, so the display never flickers.
// PARAMETERS
//   IN_W    27  width of binary input (2^27-1 = 134,217,727)
//   DIGITS  8   number of BCD digits produced; bcd width = 4*DIGITS
// PORTS
//   clk    in   1          system clock, all state changes on posedge
//   rst    in   1          asynchronous, active-high reset
//   start  in   1          conversion request, sampled on posedge clk
//   bin    in   IN_W       binary value, captured when start is accepted
//   busy   out  1          high while a conversion is in progress
//   done   out  1          one-cycle pulse: bcd/ovf just updated
//   bcd    out  4*DIGITS   packed BCD result, MS digit in top nibble
//   ovf    out  1          captured bin >= 10^DIGITS; bcd = bin mod 10^DIGITS
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE; busy=0, done=0, ovf=0, bcd=0;
//     shift/scratch registers and bit counter = 0.
//     Reset mid-conversion aborts it with no done pulse.
//   FSM states: IDLE, SHIFT.
//   IDLE: busy=0. Edge E0 with start=1 does all of:
//     - capture bin into the shift register
//     - clear the BCD scratch register
//     - counter=0, busy<=1, go to SHIFT
//     - latch the ovf compare (bin >= 10^DIGITS) into a pending flag
//   SHIFT: on each edge, in this order:
//     - add 3 to every scratch digit >= 5
//     - shift {scratch, shreg} left 1; the bit leaving the top digit is dropped
//     - counter++
//   Final shift at edge E_IN_W (counter == IN_W-1). On that edge:
//     - bcd <= final scratch value, ovf <= pending flag
//     - done <= 1, busy <= 0, state <= IDLE
//   Latency: start sampled at E0, done high in the cycle after E_IN_W
//     (IN_W+1 edges, 28 at default). Throughput: one conversion per IN_W+1 cycles.
//   done high exactly one cycle, else 0.
//   bcd and ovf change only on the done edge (or reset); hold otherwise.
//   start while busy=1: ignored; no queueing, running conversion unaffected.
//   start in the cycle done=1 (state IDLE): accepted; done drops next edge.
//   start held high continuously: back-to-back conversions, each re-sampling bin.
//   bin changes after E0: no effect on the current conversion.
//   Digits never exceed 9 for in-range input.
//   Out-of-range input: mod 10^DIGITS result comes from truncating the top digit.
//   10^DIGITS constant: computed at elaboration, width >= IN_W+1 for compare.
// TESTING
//   rst pulse, then start with bin=0 -> after 28 edges done=1, bcd=32'h00000000, ovf=0
//   bin=12345678 -> done pulse once, bcd=32'h12345678, ovf=0, busy low after done
//   bin=99999999 -> bcd=32'h99999999, ovf=0
//   bin=100000000 -> bcd=32'h00000000, ovf=1
//   bin=134217727 -> bcd=32'h34217727, ovf=1
//   Previous result 32'h12345678 and new start with bin=42:
//     - bcd holds 32'h12345678 for all 28 cycles, then becomes 32'h00000042
//   bin=5, then start pulsed at cycle 10 with bin=7 -> ignored; result 32'h00000005
//   start re-asserted in done cycle -> accepted, next done exactly 28 edges later
//   Assert rst at cycle 15 of a conversion:
//     - busy=0, bcd=0 immediately (async)
//     - no done pulse; next start converts normally

Source files
------------

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bin2bcd_seq: sequential binary to packed-BCD converter (double dabble).    |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module bin2bcd_seq #(
  parameter int IN_W   = 27,
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_W-1:0]     bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
);

  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  function automatic logic [63:0] f_pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] c_pow10_digits = f_pow10(DIGITS);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [IN_W-1:0]  r_shreg;
  logic [SW-1:0]    r_scratch;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_pend;

  logic [SW-1:0]    w_adj;
  logic [SW-1:0]    w_scr_nx;
  logic             w_ovf_cmp;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      assign w_adj[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ? r_scratch[4*g +: 4] + 4'd3
                                                             : r_scratch[4*g +: 4];
    end
  endgenerate

  // The bit shifted out of the top digit is discarded, giving bin mod 10^DIGITS
  assign w_scr_nx  = SW'({w_adj, r_shreg[IN_W-1]});
  assign w_ovf_cmp = (64'(bin) >= c_pow10_digits);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
      ovf        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shreg    <= bin;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= w_ovf_cmp;
            busy       <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scratch <= w_scr_nx;
          r_shreg   <= {r_shreg[IN_W-2:0], 1'b0};
          r_cnt     <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(IN_W - 1)) begin
            bcd     <= w_scr_nx;
            ovf     <= r_ovf_pend;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
